// File: rtl/stage1.sv
// Stage 1 of a 16-point radix-2 DIF FFT: ping-pong input banks, 4-cycle butterfly burst per frame.
// Optional macro STAGE1_SCALE_EN halves sum and difference before the twiddle multiply.
module stage1 (
  input  logic        c,
  input  logic        rst,
  input  logic        en,
  input  logic [0:15] xr,
  input  logic [0:15] xi,
  output logic [0:15] Y1p1r,
  output logic [0:15] Y1p1i,
  output logic [0:15] Y2p1r,
  output logic [0:15] Y2p1i,
  output logic [0:15] Y1p2r,
  output logic [0:15] Y1p2i,
  output logic [0:15] Y2p2r,
  output logic [0:15] Y2p2i,
  output logic        ov
);

  typedef struct packed {
    logic signed [15:0] y1r;
    logic signed [15:0] y1i;
    logic signed [15:0] y2r;
    logic signed [15:0] y2i;
  } bf_t;

  function automatic logic signed [15:0] tw_c(input logic [2:0] n);
    case (n)
      3'd0:    tw_c = 16'sd16384;
      3'd1:    tw_c = 16'sd15137;
      3'd2:    tw_c = 16'sd11585;
      3'd3:    tw_c = 16'sd6270;
      3'd4:    tw_c = 16'sd0;
      3'd5:    tw_c = -16'sd6270;
      3'd6:    tw_c = -16'sd11585;
      3'd7:    tw_c = -16'sd15137;
      default: tw_c = 16'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] tw_s(input logic [2:0] n);
    case (n)
      3'd0:    tw_s = 16'sd0;
      3'd1:    tw_s = 16'sd6270;
      3'd2:    tw_s = 16'sd11585;
      3'd3:    tw_s = 16'sd15137;
      3'd4:    tw_s = 16'sd16384;
      3'd5:    tw_s = 16'sd15137;
      3'd6:    tw_s = 16'sd11585;
      3'd7:    tw_s = 16'sd6270;
      default: tw_s = 16'sd0;
    endcase
  endfunction

  // Twiddle is W^n = C - jS, so d*W^n = (dr*C + di*S) + j(di*C - dr*S), Q1.14 floor-shifted.
  function automatic bf_t bfly(input logic signed [15:0] ar, input logic signed [15:0] ai,
                               input logic signed [15:0] br, input logic signed [15:0] bi,
                               input logic [2:0] n);
    logic signed [15:0] dr;
    logic signed [15:0] di;
    logic signed [15:0] cc;
    logic signed [15:0] ss;
    logic signed [33:0] pr;
    logic signed [33:0] pi;
    cc = tw_c(n);
    ss = tw_s(n);
`ifdef STAGE1_SCALE_EN
    bfly.y1r = 16'((17'(ar) + 17'(br)) >>> 1);
    bfly.y1i = 16'((17'(ai) + 17'(bi)) >>> 1);
    dr       = 16'((17'(ar) - 17'(br)) >>> 1);
    di       = 16'((17'(ai) - 17'(bi)) >>> 1);
`else
    bfly.y1r = ar + br;
    bfly.y1i = ai + bi;
    dr       = ar - br;
    di       = ai - bi;
`endif
    pr = 34'(dr) * 34'(cc) + 34'(di) * 34'(ss);
    pi = 34'(di) * 34'(cc) - 34'(dr) * 34'(ss);
    bfly.y2r = 16'(pr >>> 14);
    bfly.y2i = 16'(pi >>> 14);
  endfunction

  logic signed [15:0] memr_r [0:31];
  logic signed [15:0] memi_r [0:31];
  logic [3:0]         wcnt_r;
  logic               wb_r;
  logic               rb_r;
  logic               bact_r;
  logic [1:0]         bcnt_r;
  logic               ov_r;
  bf_t                p1_r;
  bf_t                p2_r;
  bf_t                bf1_s;
  bf_t                bf2_s;

  // Sample banks; never cleared by reset so only the write path is gated.
  always_ff @(posedge c) begin
    if (!rst && en) begin
      memr_r[{wb_r, wcnt_r}] <= xr;
      memi_r[{wb_r, wcnt_r}] <= xi;
    end
  end

  // Butterflies for n=k (p1) and n=k+4 (p2) from the completed bank.
  always_comb begin
    bf1_s = bfly(memr_r[{rb_r, 2'b00, bcnt_r}], memi_r[{rb_r, 2'b00, bcnt_r}],
                 memr_r[{rb_r, 2'b10, bcnt_r}], memi_r[{rb_r, 2'b10, bcnt_r}],
                 {1'b0, bcnt_r});
    bf2_s = bfly(memr_r[{rb_r, 2'b01, bcnt_r}], memi_r[{rb_r, 2'b01, bcnt_r}],
                 memr_r[{rb_r, 2'b11, bcnt_r}], memi_r[{rb_r, 2'b11, bcnt_r}],
                 {1'b1, bcnt_r});
  end

  // Write pointer, bank toggle, burst sequencing and output registers.
  always_ff @(posedge c) begin
    if (rst) begin
      wcnt_r <= 4'd0;
      wb_r   <= 1'b0;
      rb_r   <= 1'b0;
      bact_r <= 1'b0;
      bcnt_r <= 2'd0;
      ov_r   <= 1'b0;
      p1_r   <= '0;
      p2_r   <= '0;
    end else begin
      if (en) begin
        wcnt_r <= wcnt_r + 4'd1;
      end
      if (en && (wcnt_r == 4'd15)) begin
        wb_r   <= ~wb_r;
        rb_r   <= wb_r;
        bact_r <= 1'b1;
        bcnt_r <= 2'd0;
      end else if (bact_r) begin
        bcnt_r <= bcnt_r + 2'd1;
        bact_r <= (bcnt_r != 2'd3);
      end
      if (bact_r) begin
        ov_r <= 1'b1;
        p1_r <= bf1_s;
        p2_r <= bf2_s;
      end else begin
        ov_r <= 1'b0;
      end
    end
  end

  assign Y1p1r = p1_r.y1r;
  assign Y1p1i = p1_r.y1i;
  assign Y2p1r = p1_r.y2r;
  assign Y2p1i = p1_r.y2i;
  assign Y1p2r = p2_r.y1r;
  assign Y1p2i = p2_r.y1i;
  assign Y2p2r = p2_r.y2r;
  assign Y2p2i = p2_r.y2i;
  assign ov    = ov_r;

endmodule

// File: tb/tb_stage1.sv
// Self-checking bench for stage1: spec-value table per burst cycle plus a model-fed scoreboard.
module tb_stage1;
  logic        c = 1'b0;
  logic        rst, en;
  logic [0:15] xr, xi;
  logic [0:15] Y1p1r, Y1p1i, Y2p1r, Y2p1i, Y1p2r, Y1p2i, Y2p2r, Y2p2i;
  logic        ov;

  stage1 dut (
    .c(c), .rst(rst), .en(en), .xr(xr), .xi(xi),
    .Y1p1r(Y1p1r), .Y1p1i(Y1p1i), .Y2p1r(Y2p1r), .Y2p1i(Y2p1i),
    .Y1p2r(Y1p2r), .Y1p2i(Y1p2i), .Y2p2r(Y2p2r), .Y2p2i(Y2p2i), .ov(ov)
  );

  always #5 c = ~c;

  typedef struct {
    int y1p1r; int y1p1i; int y2p1r; int y2p1i;
    int y1p2r; int y1p2i; int y2p2r; int y2p2i;
  } exp_t;

  typedef struct {
    int y1p1r; int y2p1r; int y2p1i; int y1p2r; int y2p2r; int y2p2i;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t tbl[4];
  int   fxr[16];
  int   fxi[16];
  int   twc[8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int   tws[8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic longint wrap16(input longint v);
    longint r;
    r = v % 65536;
    if (r < 0) r = r + 65536;
    if (r > 32767) r = r - 65536;
    return r;
  endfunction

  function automatic longint fdiv(input longint v, input longint m);
    longint q;
    q = v / m;
    if ((v % m != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  // Reference butterfly for index n over the current frame arrays.
  task automatic model_bf(input int n, output int y1r, output int y1i, output int y2r, output int y2i);
    longint ar, ai, br, bi, dr, di;
    ar = fxr[n]; ai = fxi[n]; br = fxr[n+8]; bi = fxi[n+8];
`ifdef STAGE1_SCALE_EN
    y1r = int'(fdiv(ar + br, 2)); y1i = int'(fdiv(ai + bi, 2));
    dr = fdiv(ar - br, 2); di = fdiv(ai - bi, 2);
`else
    y1r = int'(wrap16(ar + br)); y1i = int'(wrap16(ai + bi));
    dr = wrap16(ar - br); di = wrap16(ai - bi);
`endif
    y2r = int'(wrap16(fdiv(dr * twc[n] + di * tws[n], 16384)));
    y2i = int'(wrap16(fdiv(di * twc[n] - dr * tws[n], 16384)));
  endtask

  task automatic push_model();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      model_bf(k, e.y1p1r, e.y1p1i, e.y2p1r, e.y2p1i);
      model_bf(k + 4, e.y1p2r, e.y1p2i, e.y2p2r, e.y2p2i);
      sb_q.push_back(e);
    end
  endtask

  // Scoreboard: each valid output cycle pops one expected record.
  always @(negedge c) begin
    if (ov === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("ov_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_y1p1r", s16(Y1p1r), e.y1p1r); chk("sb_y1p1i", s16(Y1p1i), e.y1p1i);
        chk("sb_y2p1r", s16(Y2p1r), e.y2p1r); chk("sb_y2p1i", s16(Y2p1i), e.y2p1i);
        chk("sb_y1p2r", s16(Y1p2r), e.y1p2r); chk("sb_y1p2i", s16(Y1p2i), e.y1p2i);
        chk("sb_y2p2r", s16(Y2p2r), e.y2p2r); chk("sb_y2p2i", s16(Y2p2i), e.y2p2i);
      end
    end
  end

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic run_frame(input int gap_at, input int gap_len);
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; xr = 16'(fxr[i]); xi = 16'(fxi[i]);
      tick();
      if (i == gap_at) begin
        en = 1'b0;
        repeat (gap_len) tick();
      end
    end
    en = 1'b0;
    push_model();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ov"}, int'(ov), 0);
    chk({nm, "_y1p1r"}, s16(Y1p1r), 0); chk({nm, "_y1p1i"}, s16(Y1p1i), 0);
    chk({nm, "_y2p1r"}, s16(Y2p1r), 0); chk({nm, "_y2p1i"}, s16(Y2p1i), 0);
    chk({nm, "_y1p2r"}, s16(Y1p2r), 0); chk({nm, "_y1p2i"}, s16(Y1p2i), 0);
    chk({nm, "_y2p2r"}, s16(Y2p2r), 0); chk({nm, "_y2p2i"}, s16(Y2p2i), 0);
  endtask

  // Ramp frame expectations, checked at edges E+1..E+4, then ov low after E+5.
  task automatic table_check(input string nm);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk({nm, "_ov"}, int'(ov), 1);
      chk({nm, "_y1p1r"}, s16(Y1p1r), tbl[k].y1p1r);
      chk({nm, "_y2p1r"}, s16(Y2p1r), tbl[k].y2p1r);
      chk({nm, "_y2p1i"}, s16(Y2p1i), tbl[k].y2p1i);
      chk({nm, "_y1p2r"}, s16(Y1p2r), tbl[k].y1p2r);
      chk({nm, "_y2p2r"}, s16(Y2p2r), tbl[k].y2p2r);
      chk({nm, "_y2p2i"}, s16(Y2p2i), tbl[k].y2p2i);
    end
    tick();
    chk({nm, "_ov_end"}, int'(ov), 0);
  endtask

  task automatic ramp();
    for (int i = 0; i < 16; i++) begin
      fxr[i] = i; fxi[i] = 0;
    end
  endtask

  initial begin
    int cxr[16];
    int exp_w;
    tbl[0] = '{8, -8, 0, 16, 0, 8};
    tbl[1] = '{10, -8, 3, 18, 3, 7};
    tbl[2] = '{12, -6, 5, 20, 5, 5};
    tbl[3] = '{14, -4, 7, 22, 7, 3};

    rst = 1'b1; en = 1'b0; xr = '0; xi = '0;
    tick(); tick();
    rst = 1'b0;
    chk_zero("reset");

    ramp();
    run_frame(-1, 0);
    table_check("ramp");

    run_frame(7, 3);
    table_check("ramp_gap");

    for (int i = 0; i < 16; i++) begin
      fxr[i] = 0; fxi[i] = 0;
    end
    fxr[0] = 32767; fxr[8] = 32767;
`ifdef STAGE1_SCALE_EN
    exp_w = 32767;
`else
    exp_w = -2;
`endif
    run_frame(-1, 0);
    tick();
    chk("wrap_y1p1r", s16(Y1p1r), exp_w);
    repeat (4) tick();
    chk("wrap_ov_end", int'(ov), 0);

    for (int i = 0; i < 16; i++) begin
      cxr[i] = int'($urandom_range(20000, 0)) - 10000;
      fxr[i] = cxr[i];
      fxi[i] = int'($urandom_range(20000, 0)) - 10000;
    end
    run_frame(-1, 0);
    for (int i = 0; i < 16; i++) fxr[i] = cxr[i] + 1;
    run_frame(-1, 0);
    tick();
`ifdef STAGE1_SCALE_EN
    chk("b2b_y1p1r", s16(Y1p1r), int'(fdiv(longint'(cxr[0]) + cxr[8] + 2, 2)));
`else
    chk("b2b_y1p1r", s16(Y1p1r), int'(wrap16(longint'(cxr[0]) + cxr[8] + 2)));
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("abort");
    sb_q.delete();
    repeat (6) tick();
    chk("abort_ov_idle", int'(ov), 0);

    for (int i = 0; i < 5; i++) begin
      en = 1'b1; xr = 16'(i * 1000 + 7); xi = 16'(i);
      tick();
    end
    en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    ramp();
    run_frame(-1, 0);
    table_check("after_rst");

    repeat (2) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
